// File: rtl/mult_seq_ctrl_if.sv
// Bundle of the handshake, operand, result and half-width multiplier signals
// exchanged between mult_seq_ctrl (slave side) and its environment (master side).
interface mult_seq_ctrl_if #(parameter int WIDTH = 8);
  localparam int HALF = WIDTH / 2;

  logic                 start;
  logic                 clear;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic [HALF-1:0]      mul_a;
  logic [HALF-1:0]      mul_b;
  logic [2*HALF-1:0]    mul_p;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport slave (
    input  start, clear, a_in, b_in, mul_p,
    output mul_a, mul_b, busy, done, product
  );

  modport master (
    output start, clear, a_in, b_in, mul_p,
    input  mul_a, mul_b, busy, done, product
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Four-step sequencing controller for a WIDTHxWIDTH multiply built from an external
// HALFxHALF multiplier. Optional macro ZERO_SKIP_EN short-circuits zero operands.
//
// state | meaning
// IDLE  | waiting for start, multiplier inputs held at zero
// CALC  | issuing partial product for step 0..3 and accumulating
// DONE  | result valid, done pulse; start here chains the next product
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  mult_seq_ctrl_if.slave  bus
);
  localparam int HALF = WIDTH / 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [HALF-1:0]    sel_a, sel_b;
  logic [2*WIDTH-1:0] part_ext;
  logic [2*WIDTH-1:0] part_shf;
  logic [2*WIDTH-1:0] acc_sum;

  // Step order lo*lo, hi*lo, lo*hi, hi*hi keeps the shift amounts 0, HALF, HALF, WIDTH.
  always_comb begin
    sel_a    = a_q[HALF-1:0];
    sel_b    = b_q[HALF-1:0];
    part_ext = {{WIDTH{1'b0}}, bus.mul_p};
    part_shf = part_ext;
    case (step_q)
      2'd0: begin
        sel_a    = a_q[HALF-1:0];
        sel_b    = b_q[HALF-1:0];
        part_shf = part_ext;
      end
      2'd1: begin
        sel_a    = a_q[WIDTH-1:HALF];
        sel_b    = b_q[HALF-1:0];
        part_shf = part_ext << HALF;
      end
      2'd2: begin
        sel_a    = a_q[HALF-1:0];
        sel_b    = b_q[WIDTH-1:HALF];
        part_shf = part_ext << HALF;
      end
      default: begin
        sel_a    = a_q[WIDTH-1:HALF];
        sel_b    = b_q[WIDTH-1:HALF];
        part_shf = part_ext << WIDTH;
      end
    endcase
    acc_sum = acc_q + part_shf;
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    product_d = product_q;

    if (bus.clear) begin
      state_d = ST_IDLE;
      step_d  = 2'd0;
      acc_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (bus.start) begin
            a_d     = bus.a_in;
            b_d     = bus.b_in;
            acc_d   = '0;
            step_d  = 2'd0;
            state_d = ST_CALC;
`ifdef ZERO_SKIP_EN
            if ((bus.a_in == '0) || (bus.b_in == '0)) begin
              product_d = '0;
              state_d   = ST_DONE;
            end
`endif
          end
        end
        ST_CALC: begin
          acc_d  = acc_sum;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            product_d = acc_sum;
            step_d    = 2'd0;
            state_d   = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          step_d  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      step_q    <= 2'd0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      product_q <= product_d;
    end
  end

  assign bus.mul_a   = (state_q == ST_CALC) ? sel_a : '0;
  assign bus.mul_b   = (state_q == ST_CALC) ? sel_b : '0;
  assign bus.busy    = (state_q == ST_CALC);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.product = product_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: accepted operands push a*b, every done pulse
// pops and compares the product; directed checks cover timing, abort and reset.
module tb_mult_seq_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   done_cnt;
  logic [2*WIDTH-1:0] sb_q[$];

  mult_seq_ctrl_if #(.WIDTH(WIDTH)) io ();

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (io)
  );

  // Behavioural stand-in for the external half-width multiplier.
  assign io.mul_p = WIDTH'(io.mul_a) * WIDTH'(io.mul_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start cycle; push=1 when this start will be accepted and completed.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit push);
    io.a_in  = a;
    io.b_in  = b;
    io.start = 1'b1;
    if (push) sb_q.push_back((2*WIDTH)'(a) * (2*WIDTH)'(b));
    tick();
    io.start = 1'b0;
  endtask

  // After the start edge n: waits for done and checks it is sampled at edge n+exp_lat.
  task automatic wait_done(input string tag, input int exp_lat);
    int c;
    c = 0;
    while (io.done !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    chk(tag, c + 1, exp_lat);
  endtask

  always @(negedge clk) begin
    if (reset && io.done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else chk("sb_product", io.product, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ea[4];
    int eb[4];
    int saved;
    ea = '{2, 1, 2, 1};
    eb = '{4, 4, 3, 3};
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    io.start = 1'b0;
    io.clear = 1'b0;
    io.a_in  = '0;
    io.b_in  = '0;
    reset    = 1'b0;
    #23;
    chk("rst_busy", io.busy, 0);
    chk("rst_done", io.done, 0);
    chk("rst_product", io.product, 0);
    chk("rst_mul_a", io.mul_a, 0);
    chk("rst_mul_b", io.mul_b, 0);
    reset = 1'b1;
    tick();

    // FF*FF: busy for four cycles, done for one, product FE01.
    start_op(8'hFF, 8'hFF, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ff_busy%0d", k), io.busy, 1);
      chk($sformatf("ff_nodone%0d", k), io.done, 0);
      tick();
    end
    chk("ff_done", io.done, 1);
    chk("ff_busy_low", io.busy, 0);
    chk("ff_product", io.product, 16'hFE01);
    tick();
    chk("ff_done_pulse", io.done, 0);
    chk("ff_product_hold", io.product, 16'hFE01);

    // 12*34: check nibble sequence on the multiplier inputs.
    start_op(8'h12, 8'h34, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("seq_mul_a%0d", k), io.mul_a, ea[k]);
      chk($sformatf("seq_mul_b%0d", k), io.mul_b, eb[k]);
      tick();
    end
    chk("seq_done", io.done, 1);
    chk("seq_product", io.product, 16'h03A8);
    tick();
    chk("idle_mul_a", io.mul_a, 0);

    // Start during CALC ignored; start held through DONE chains FF*FF back-to-back.
    start_op(8'h12, 8'h34, 1'b1);
    io.a_in  = 8'hFF;
    io.b_in  = 8'hFF;
    io.start = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("b2b_done1", io.done, 1);
    chk("b2b_product1", io.product, 16'h03A8);
    sb_q.push_back(16'hFE01);
    tick();
    io.start = 1'b0;
    chk("b2b_busy", io.busy, 1);
    for (int k = 0; k < 4; k++) tick();
    chk("b2b_done2", io.done, 1);
    chk("b2b_product2", io.product, 16'hFE01);
    tick();

    // Clear mid-CALC aborts with no done and keeps the prior product.
    start_op(8'h12, 8'h34, 1'b1);
    wait_done("lat_1234", 5);
    tick();
    saved = done_cnt;
    start_op(8'hFF, 8'hFF, 1'b0);
    tick();
    tick();
    io.clear = 1'b1;
    tick();
    io.clear = 1'b0;
    chk("clr_busy", io.busy, 0);
    chk("clr_done", io.done, 0);
    chk("clr_product", io.product, 16'h03A8);
    io.clear = 1'b1;
    io.start = 1'b1;
    tick();
    io.clear = 1'b0;
    io.start = 1'b0;
    chk("clr_start_busy", io.busy, 0);
    for (int k = 0; k < 6; k++) tick();
    chk("clr_no_done", done_cnt, saved);
    chk("clr_product_hold", io.product, 16'h03A8);

    // Asynchronous reset between edges mid-CALC.
    start_op(8'hFF, 8'hFF, 1'b0);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", io.busy, 0);
    chk("arst_done", io.done, 0);
    chk("arst_product", io.product, 0);
    chk("arst_mul_a", io.mul_a, 0);
    chk("arst_mul_b", io.mul_b, 0);
    #2 reset = 1'b1;
    tick();
    start_op(8'h0A, 8'h0B, 1'b1);
    wait_done("lat_0a0b", 5);
    chk("arst_after_product", io.product, 16'h006E);
    tick();

    // Zero operand: skipped when ZERO_SKIP_EN, otherwise full four steps.
    start_op(8'h00, 8'h55, 1'b1);
`ifdef ZERO_SKIP_EN
    chk("zero_mul_a", io.mul_a, 0);
    wait_done("lat_zero", 1);
`else
    wait_done("lat_zero", 5);
`endif
    chk("zero_product", io.product, 0);
    tick();
    tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
